// File: rtl/retire_trace_unit.sv
// Retire-trace generator: pairs each fetched PC with its write-back result and emits the
// 70-bit inst_retire word. Optional retire/cycle counters are built when RETIRE_PERF_CNT_EN is defined.
module retire_trace_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_fire,
  input  logic [31:0] pc_fetch,
  input  logic        wb_valid,
  input  logic        wb_rf_wen,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  output logic [69:0] inst_retire,
  output logic        protocol_err,
  output logic [31:0] retire_cnt,
  output logic [31:0] cycle_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_err_set;
  logic        w_rf_en;
  logic [31:0] r_pc_hold;
  logic [69:0] r_retire;
  logic        r_protocol_err;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (inst_req_fire) w_state_nxt = ST_HELD;
        if (wb_valid)      w_err_set   = 1'b1;
      end
      ST_HELD: begin
        if (wb_valid && !inst_req_fire) w_state_nxt = ST_EMPTY;
        if (inst_req_fire && !wb_valid) w_err_set   = 1'b1;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Writes to x0 retire but must not look like register-file updates.
  assign w_rf_en = wb_rf_wen && (wb_rf_waddr != 5'd0);

  // The retire word below reads the old pc_hold, so a same-cycle fire cannot leak into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_hold <= RESET_PC;
    end else if (inst_req_fire) begin
      r_pc_hold <= pc_fetch;
    end
  end

  // NOTE: reset is tested first so it overrides a concurrent wb_valid or fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire <= {1'b0, 5'd0, 32'd0, RESET_PC};
    end else if (wb_valid) begin
      r_retire <= {w_rf_en, wb_rf_waddr, wb_rf_wdata, r_pc_hold};
    end else begin
      r_retire[69] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if (w_err_set) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign inst_retire  = r_retire;
  assign protocol_err = r_protocol_err;

`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= 32'd0;
      r_cycle_cnt  <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (wb_valid) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign cycle_cnt  = r_cycle_cnt;
`else
  assign retire_cnt = 32'd0;
  assign cycle_cnt  = 32'd0;
`endif

endmodule
